// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the CNN output-channel scheduler.
// Default widths describe the 5x5, 8-bit pixel, 7-bit weight, 4-channel build.
package cnn_pkg;

    localparam int CNN_I_F_BW = 8;
    localparam int CNN_KX     = 5;
    localparam int CNN_KY     = 5;
    localparam int CNN_W_BW   = 7;
    localparam int CNN_CI     = 1;
    localparam int CNN_CO     = 4;
    localparam int CNN_ACI_BW = 22;

    // Scheduler phases: wait for a window, issue it once per channel,
    // collect the channel results, then hold the packed vector.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/cnn_co_weight_sel.sv
// CO:1 weight-set multiplexer. Picks the weight set for the output channel
// currently being issued; an out-of-range index yields all zeros.
module cnn_co_weight_sel #(
    parameter int CO    = 4,
    parameter int SET_W = 175,
    parameter int CNT_W = 3
) (
    input  logic [CO*SET_W-1:0] weights_i,
    input  logic [CNT_W-1:0]    sel_i,
    output logic [SET_W-1:0]    set_o
);

    // Select one weight set by channel index.
    always_comb begin
        set_o = '0;
        for (int c = 0; c < CO; c++) begin
            if (sel_i == CNT_W'(c)) begin
                set_o = weights_i[c*SET_W +: SET_W];
            end
        end
    end

endmodule

// File: rtl/cnn_co_scheduler.sv
// Shares one channel-accumulate datapath across CO output channels: latches a
// window, issues it CO times with each channel's weight set, gathers the CO
// results in issue order and presents them as one packed vector.
// Optional feature: define CNN_SCHED_RELU_EN to clamp negative results to zero
// as they are stored (latency unchanged).
module cnn_co_scheduler
    import cnn_pkg::*;
#(
    parameter int I_F_BW = CNN_I_F_BW,
    parameter int KX     = CNN_KX,
    parameter int KY     = CNN_KY,
    parameter int W_BW   = CNN_W_BW,
    parameter int CI     = CNN_CI,
    parameter int CO     = CNN_CO,
    parameter int ACI_BW = CNN_ACI_BW
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic [KX*KY*I_F_BW-1:0]        i_window,
    input  logic [CO*CI*KX*KY*W_BW-1:0]    i_cnn_weight,
    output logic                           o_acc_valid,
    output logic [KX*KY*I_F_BW-1:0]        o_acc_window,
    output logic [CI*KX*KY*W_BW-1:0]       o_acc_weight,
    input  logic                           i_acc_valid,
    input  logic [ACI_BW-1:0]              i_acc_ci_acc,
    output logic                           o_ot_valid,
    input  logic                           i_ot_ready,
    output logic [CO*ACI_BW-1:0]           o_ot_co_acc,
    output logic                           o_busy,
    output logic                           o_err
);

    localparam int WIN_W = KX*KY*I_F_BW;
    localparam int SET_W = CI*KX*KY*W_BW;
    localparam int CNT_W = $clog2(CO+1);

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    issueCnt_q, issueCnt_d;
    logic [CNT_W-1:0]    rspCnt_q, rspCnt_d;
    logic                err_q, err_d;
    logic [WIN_W-1:0]    window_q;
    logic [ACI_BW-1:0]   slot_q [CO];
    logic                storeEn;
    logic                rspAccepted;
    logic                rspDone;
    logic [ACI_BW-1:0]   storeVal;
    logic [SET_W-1:0]    selSet;

`ifdef CNN_SCHED_RELU_EN
    assign storeVal = i_acc_ci_acc[ACI_BW-1] ? '0 : i_acc_ci_acc;
`else
    assign storeVal = i_acc_ci_acc;
`endif

    cnn_co_weight_sel #(
        .CO    (CO),
        .SET_W (SET_W),
        .CNT_W (CNT_W)
    ) u_weight_sel (
        .weights_i (i_cnn_weight),
        .sel_i     (issueCnt_q),
        .set_o     (selSet)
    );

    // State, counters and the sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            issueCnt_q <= '0;
            rspCnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            issueCnt_q <= issueCnt_d;
            rspCnt_q   <= rspCnt_d;
            err_q      <= err_d;
        end
    end

    // Window latch: captured only on the accepting handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_q <= '0;
        end else if (state_q == ST_IDLE && i_in_valid) begin
            window_q <= i_window;
        end
    end

    // Result slots: each accepted response fills the next slot in issue order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CO; c++) begin
                slot_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CO; c++) begin
                if (storeEn && rspCnt_q == CNT_W'(c)) begin
                    slot_q[c] <= storeVal;
                end
            end
        end
    end

    // Next-state logic, response accounting and handshake outputs.
    always_comb begin
        state_d     = state_q;
        issueCnt_d  = issueCnt_q;
        rspCnt_d    = rspCnt_q;
        err_d       = err_q;
        storeEn     = 1'b0;
        o_in_ready  = 1'b0;
        o_acc_valid = 1'b0;
        o_ot_valid  = 1'b0;

        rspAccepted = i_acc_valid
                      && (state_q == ST_ISSUE || state_q == ST_WAIT)
                      && (rspCnt_q < CNT_W'(CO));
        rspDone     = rspAccepted && (rspCnt_q == CNT_W'(CO-1));

        if (rspAccepted) begin
            storeEn  = 1'b1;
            rspCnt_d = rspCnt_q + CNT_W'(1);
        end else if (i_acc_valid) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_acc_valid = 1'b1;
                if (issueCnt_q == CNT_W'(CO-1)) begin
                    state_d = ST_WAIT;
                end else begin
                    issueCnt_d = issueCnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (rspDone || rspCnt_q == CNT_W'(CO)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                o_ot_valid = 1'b1;
                if (i_ot_ready) begin
                    state_d    = ST_IDLE;
                    issueCnt_d = '0;
                    rspCnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pack the result slots into the output vector, channel 0 in the low bits.
    always_comb begin
        o_ot_co_acc = '0;
        for (int c = 0; c < CO; c++) begin
            o_ot_co_acc[c*ACI_BW +: ACI_BW] = slot_q[c];
        end
    end

    assign o_acc_window = window_q;
    assign o_acc_weight = (state_q == ST_IDLE) ? '0 : selSet;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_err        = err_q;

endmodule

// File: tb/tb_cnn_co_scheduler.sv
// Directed bench for cnn_co_scheduler. The datapath is modelled as a 3-stage
// pipeline computing dot(window, weight set); weight set c is all (c+1), so
// each channel result is sum(window)*(c+1).
module tb_cnn_co_scheduler;

    localparam int CO     = 4;
    localparam int ACI_BW = 22;
    localparam int WIN_W  = 200;
    localparam int SET_W  = 175;

    logic                   clk;
    logic                   reset_n;
    logic                   i_in_valid;
    logic                   o_in_ready;
    logic [WIN_W-1:0]       i_window;
    logic [CO*SET_W-1:0]    i_cnn_weight;
    logic                   o_acc_valid;
    logic [WIN_W-1:0]       o_acc_window;
    logic [SET_W-1:0]       o_acc_weight;
    logic                   i_acc_valid;
    logic [ACI_BW-1:0]      i_acc_ci_acc;
    logic                   o_ot_valid;
    logic                   i_ot_ready;
    logic [CO*ACI_BW-1:0]   o_ot_co_acc;
    logic                   o_busy;
    logic                   o_err;

    int checks;
    int failures;

    logic                   spurValid;
    logic [ACI_BW-1:0]      spurData;
    logic                   negCh2;
    logic [2:0]             pv;
    logic [ACI_BW-1:0]      pd [3];
    int                     beatCnt;

    cnn_co_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_window     (i_window),
        .i_cnn_weight (i_cnn_weight),
        .o_acc_valid  (o_acc_valid),
        .o_acc_window (o_acc_window),
        .o_acc_weight (o_acc_weight),
        .i_acc_valid  (i_acc_valid),
        .i_acc_ci_acc (i_acc_ci_acc),
        .o_ot_valid   (o_ot_valid),
        .i_ot_ready   (i_ot_ready),
        .o_ot_co_acc  (o_ot_co_acc),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ACI_BW-1:0] dot(input logic [WIN_W-1:0] win, input logic [SET_W-1:0] wt);
        int s;
        s = 0;
        for (int k = 0; k < 25; k++) begin
            s += int'(win[k*8 +: 8]) * int'($signed(wt[k*7 +: 7]));
        end
        return ACI_BW'(s);
    endfunction

    function automatic logic [SET_W-1:0] setVec(input int c);
        logic [SET_W-1:0] v;
        v = '0;
        for (int k = 0; k < 25; k++) v[k*7 +: 7] = 7'(c + 1);
        return v;
    endfunction

    function automatic logic [WIN_W-1:0] fillWin(input int px);
        logic [WIN_W-1:0] v;
        v = '0;
        for (int k = 0; k < 25; k++) v[k*8 +: 8] = 8'(px);
        return v;
    endfunction

    function automatic logic [CO*ACI_BW-1:0] packVec(input int s0, input int s1, input int s2, input int s3);
        return {ACI_BW'(s3), ACI_BW'(s2), ACI_BW'(s1), ACI_BW'(s0)};
    endfunction

    // Fixed-latency datapath model, reset together with the scheduler.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv      <= '0;
            beatCnt <= 0;
            pd[0]   <= '0;
            pd[1]   <= '0;
            pd[2]   <= '0;
        end else begin
            pv      <= {pv[1:0], o_acc_valid};
            pd[0]   <= (negCh2 && beatCnt == 2) ? 22'h3FFFFB : dot(o_acc_window, o_acc_weight);
            pd[1]   <= pd[0];
            pd[2]   <= pd[1];
            beatCnt <= o_acc_valid ? beatCnt + 1 : 0;
        end
    end

    assign i_acc_valid  = pv[2] | spurValid;
    assign i_acc_ci_acc = pv[2] ? pd[2] : spurData;

    task automatic checkOutput(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIN_W-1:0] px);
        int n;
        n = 0;
        while (!o_in_ready && n < 100) begin
            tick();
            n++;
        end
        checkOutput("in_ready_before_send", 768'(o_in_ready), 768'(1));
        i_in_valid = 1'b1;
        i_window   = px;
        tick();
        i_in_valid = 1'b0;
        checkOutput("busy_after_accept", 768'(o_busy), 768'(1));
    endtask

    task automatic waitOut(output int cycles, output int beats, output int readyHigh);
        cycles    = 0;
        beats     = int'(o_acc_valid);
        readyHigh = 0;
        while (!o_ot_valid && cycles < 60) begin
            tick();
            cycles++;
            beats     += int'(o_acc_valid);
            readyHigh += int'(o_in_ready);
        end
        checkOutput("ot_valid_seen", 768'(o_ot_valid), 768'(1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"},  768'(o_in_ready),   768'(1));
        checkOutput({tag, "_acc_valid"}, 768'(o_acc_valid),  768'(0));
        checkOutput({tag, "_acc_win"},   768'(o_acc_window), 768'(0));
        checkOutput({tag, "_acc_wt"},    768'(o_acc_weight), 768'(0));
        checkOutput({tag, "_ot_valid"},  768'(o_ot_valid),   768'(0));
        checkOutput({tag, "_ot_vec"},    768'(o_ot_co_acc),  768'(0));
        checkOutput({tag, "_busy"},      768'(o_busy),       768'(0));
        checkOutput({tag, "_err"},       768'(o_err),        768'(0));
    endtask

    // Watchdog: a stuck run still reports and terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        int cyc, beats, rdy, got;
        int sum;
        logic [WIN_W-1:0]      px;
        logic [CO*ACI_BW-1:0]  expVec, heldVec;
        logic [SET_W-1:0]      w0, w3;

        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        i_in_valid = 1'b0;
        i_window = '0;
        i_ot_ready = 1'b0;
        spurValid = 1'b0;
        spurData = '0;
        negCh2 = 1'b0;
        w0 = setVec(0);
        w3 = setVec(3);
        for (int c = 0; c < CO; c++) i_cnn_weight[c*SET_W +: SET_W] = setVec(c);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checkResetState("reset");

        // Window of all ones, output held back for 10 cycles.
        applyStimulus(fillWin(1));
        checkOutput("w1_first_beat", 768'(o_acc_valid), 768'(1));
        checkOutput("w1_first_weight", 768'(o_acc_weight), 768'(w0));
        waitOut(cyc, beats, rdy);
        checkOutput("w1_latency", 768'(cyc), 768'(7));
        checkOutput("w1_beats", 768'(beats), 768'(4));
        checkOutput("w1_in_ready_low", 768'(rdy), 768'(0));
        checkOutput("w1_weight_hold", 768'(o_acc_weight), 768'(w3));
        expVec = packVec(25, 50, 75, 100);
        checkOutput("w1_vec", 768'(o_ot_co_acc), 768'(expVec));

        i_in_valid = 1'b1;
        i_window   = fillWin(9);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_ot_valid", 768'(o_ot_valid), 768'(1));
            checkOutput("bp_vec", 768'(o_ot_co_acc), 768'(expVec));
            checkOutput("bp_in_ready", 768'(o_in_ready), 768'(0));
        end
        checkOutput("bp_window_kept", 768'(o_acc_window), 768'(fillWin(1)));
        i_in_valid = 1'b0;
        i_ot_ready = 1'b1;
        tick();
        checkOutput("hs_ot_valid", 768'(o_ot_valid), 768'(0));
        checkOutput("hs_in_ready", 768'(o_in_ready), 768'(1));
        checkOutput("hs_busy", 768'(o_busy), 768'(0));

        // Negative result on channel 2.
        negCh2 = 1'b1;
        applyStimulus(fillWin(1));
        waitOut(cyc, beats, rdy);
        negCh2 = 1'b0;
`ifdef CNN_SCHED_RELU_EN
        expVec = packVec(25, 50, 0, 100);
`else
        expVec = packVec(25, 50, 'h3FFFFB, 100);
`endif
        checkOutput("neg_vec", 768'(o_ot_co_acc), 768'(expVec));
        checkOutput("neg_latency", 768'(cyc), 768'(7));
        tick();
        checkOutput("neg_done_idle", 768'(o_in_ready), 768'(1));

        // Spurious response while idle.
        heldVec = o_ot_co_acc;
        spurValid = 1'b1;
        spurData  = 22'h000123;
        tick();
        spurValid = 1'b0;
        checkOutput("spur_err", 768'(o_err), 768'(1));
        checkOutput("spur_vec_unchanged", 768'(o_ot_co_acc), 768'(heldVec));
        checkOutput("spur_ot_valid", 768'(o_ot_valid), 768'(0));
        checkOutput("spur_in_ready", 768'(o_in_ready), 768'(1));

        // Window of pixel values 0..24 after the error.
        px = '0;
        for (int k = 0; k < 25; k++) px[k*8 +: 8] = 8'(k);
        applyStimulus(px);
        waitOut(cyc, beats, rdy);
        checkOutput("w3_vec", 768'(o_ot_co_acc), 768'(packVec(300, 600, 900, 1200)));
        checkOutput("w3_err_sticky", 768'(o_err), 768'(1));
        tick();

        // Reset while waiting with two of four responses stored.
        applyStimulus(fillWin(2));
        repeat (5) tick();
        checkOutput("mid_busy", 768'(o_busy), 768'(1));
        reset_n = 1'b0;
        #2;
        checkResetState("mid_reset_low");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) tick();
        checkResetState("mid_reset_after");
        applyStimulus(fillWin(3));
        waitOut(cyc, beats, rdy);
        checkOutput("post_reset_vec", 768'(o_ot_co_acc), 768'(packVec(75, 150, 225, 300)));
        checkOutput("post_reset_latency", 768'(cyc), 768'(7));
        tick();

        // Ten windows with random downstream readiness.
        for (int w = 0; w < 10; w++) begin
            px  = '0;
            sum = 0;
            for (int k = 0; k < 25; k++) begin
                px[k*8 +: 8] = 8'($urandom_range(0, 255));
                sum += int'(px[k*8 +: 8]);
            end
            expVec = packVec(sum, 2*sum, 3*sum, 4*sum);
            applyStimulus(px);
            got = 0;
            for (int n = 0; n < 200 && got == 0; n++) begin
                tick();
                i_ot_ready = 1'($urandom_range(0, 1));
                if (o_ot_valid && i_ot_ready) got = 1;
            end
            checkOutput("rnd_handshake", 768'(got), 768'(1));
            checkOutput($sformatf("rnd_vec_%0d", w), 768'(o_ot_co_acc), 768'(expVec));
        end
        tick();
        checkOutput("final_idle", 768'(o_in_ready), 768'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
